pe_feeder_1st: RTL and testbench
================================

// Module: pe_feeder_1st
// PURPOSE
//  Window sequencer/initiator for the first-layer MAC processing element. Holds a KxK signed
//  8-bit kernel, streams one KxK pixel window (raster order) into the PE, captures the 32-bit
//  accumulated sum, flushes the PE, and presents each window result on a valid/ready output.
//  Sits between the line-buffer/window generator (upstream) and the output writer (downstream).
// PARAMETERS
//  K       3   kernel dimension; NW = K*K MAC cycles per window
//  ADDR_W  4   weight address width; 2**ADDR_W >= NW required
// PORTS
//  clk         in   1       system clock, rising edge
//  rst_n       in   1       asynchronous active-low reset
//  run         in   1       1 = process windows; 0 = stop before starting the next window
//  w_we        in   1       kernel write strobe
//  w_addr      in   ADDR_W  kernel index 0..NW-1, raster order
//  w_data      in   8       signed kernel value
//  w_busy      out  1       1 while a window is in progress; writes are ignored
//  pix_valid   in   1       upstream pixel valid
//  pix_ready   out  1       upstream pixel ready
//  pix_data    in   8       signed pixel
//  pe_en       out  1       PE accumulate enable
//  pe_flush    out  1       PE accumulator clear
//  pe_weight   out  8       weight presented to PE
//  pe_pixel    out  8       pixel presented to PE
//  pe_result   in   32      PE accumulator output (registered inside PE)
//  res_valid   out  1       window result valid
//  res_ready   in   1       downstream ready
//  res_data    out  32      signed window sum
// BEHAVIOUR
//  PE contract: at a clk edge, pe_flush=1 -> acc<=0; else pe_en=1 -> acc<=acc+w*p. pe_result
//    reflects the update one cycle later. The feeder never asserts pe_en and pe_flush together.
//  Reset values: pe_en=0, pe_flush=0, pix_ready=0, res_valid=0, res_data=0, w_busy=0, cnt=0,
//    state=FLUSH. Kernel registers reset to 0.
//  FSM states: FLUSH, IDLE, MAC, CAPT.
//    FLUSH: pe_flush=1 for exactly one cycle; cnt<=0; next state IDLE.
//    IDLE:  if run=1, go to MAC; else stay. Kernel writes are accepted only in IDLE/FLUSH.
//    MAC:   pix_ready=1, pe_en=pix_valid, pe_weight=kernel[cnt], pe_pixel=pix_data (comb).
//           On a handshake, cnt++. Handshake with cnt==NW-1 -> CAPT. pix_valid gaps stall
//           the window: no pe_en, cnt holds.
//    CAPT:  pe_result is final. If res_valid=0 or res_ready=1, load res_data<=pe_result,
//           set res_valid<=1, go to FLUSH. Otherwise stall in CAPT; the PE holds its sum.
//  Output: res_valid stays 1 and res_data stays stable until a res_ready handshake. A load in
//    CAPT in the same cycle as a handshake keeps res_valid=1 and carries the new data.
//  w_busy = (state==MAC || state==CAPT). A w_we while busy is dropped silently.
//    w_addr>=NW is dropped.
//  Latency: last pixel handshake at cycle t -> res_valid=1 at t+2 with no backpressure.
//    Throughput: NW+2 cycles per window (MAC NW, CAPT 1, FLUSH 1); IDLE is skipped when
//    run=1.
//  run=0 mid-window does not abort; the window completes and the FSM parks in IDLE after FLUSH.
//  Async reset mid-window discards the partial sum and any pending result. The FSM restarts
//    in FLUSH.
//  Arithmetic: no internal width growth; the 32-bit sum is passed through unmodified
//    (8x8 products, NW<=65536 cannot overflow).
// CONFIGURATION
//  PE_FEEDER_RELU_EN defined:   CAPT loads res_data = (pe_result<0) ? 0 : pe_result.
//  PE_FEEDER_RELU_EN undefined: CAPT loads res_data = pe_result (signed, unclamped).
// TESTING
//  1 Kernel all 1, pixels 1..9, res_ready=1 -> res_data=45; res_valid one cycle, 2 cycles
//    after the 9th pixel.
//  2 Kernel all 0xFF(-1), pixels all 127 -> res_data=-1143 (0xFFFFFB89); with
//    PE_FEEDER_RELU_EN -> 0.
//  3 Same as test 1 with pix_valid toggling 1,0,1,0... -> same sum 45; pe_en only on
//    handshakes; cnt holds during gaps.
//  4 Two back-to-back windows with res_ready=0 -> 1st result held stable.
//    2nd window stalls in CAPT; pe_flush is not asserted until res_ready=1.
//    Results then emerge in order.
//  5 w_we during MAC (addr 0, data 5) -> dropped; the current and next window use the old
//    kernel; w_busy=1.
//  6 rst_n low after 4 pixels -> all outputs return to reset values; the next full window
//    yields the correct sum.

Source files
------------

// File: rtl/pe_feeder_1st.sv
// pe_feeder_1st: window sequencer for the first-layer MAC processing element.
// It holds a KxK signed 8-bit kernel and streams one KxK pixel window into the PE
// in raster order. It then captures the PE sum, flushes the PE, and offers the sum
// on a valid/ready port.
// Optional feature macro: PE_FEEDER_RELU_EN (clamp negative window sums to 0).
module pe_feeder_1st #(
  parameter int K      = 3,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run_i,
  input  logic              w_we_i,
  input  logic [ADDR_W-1:0] w_addr_i,
  input  logic [7:0]        w_data_i,
  output logic              w_busy_o,
  input  logic              pix_valid_i,
  output logic              pix_ready_o,
  input  logic [7:0]        pix_data_i,
  output logic              pe_en_o,
  output logic              pe_flush_o,
  output logic [7:0]        pe_weight_o,
  output logic [7:0]        pe_pixel_o,
  input  logic [31:0]       pe_result_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [31:0]       res_data_o
);
  localparam int                NW   = K * K;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NW - 1);

  typedef enum logic [1:0] {FLUSH, IDLE, MAC, CAPT} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              pe_flush_q;
  logic              res_valid_q;
  logic [31:0]       res_data_q;
  logic [7:0]        kern_q [NW];

  logic              in_mac;
  logic              w_ok;
  logic              res_load;
  logic [31:0]       capt_val;

  assign in_mac   = (state_q == MAC);
  // Kernel is frozen while a window is in flight; out-of-range addresses are dropped.
  assign w_ok     = w_we_i && (state_q == IDLE || state_q == FLUSH) &&
                    ({1'b0, w_addr_i} < (ADDR_W+1)'(NW));
  // Output slot is free if empty or being drained this cycle.
  assign res_load = (state_q == CAPT) && (!res_valid_q || res_ready_i);

`ifdef PE_FEEDER_RELU_EN
  assign capt_val = pe_result_i[31] ? 32'd0 : pe_result_i;
`else
  assign capt_val = pe_result_i;
`endif

  // Kernel register file, written only between windows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NW; i++) kern_q[i] <= '0;
    end else if (w_ok) begin
      kern_q[w_addr_i] <= w_data_i;
    end
  end

  // Window sequencer: FLUSH -> (IDLE) -> MAC x NW -> CAPT -> FLUSH, with registered
  // flush and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FLUSH;
      cnt_q       <= '0;
      pe_flush_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      // A downstream handshake empties the slot; a load in CAPT below overrides it.
      if (res_valid_q && res_ready_i) res_valid_q <= 1'b0;
      unique case (state_q)
        // pe_flush is registered. After reset the first FLUSH cycle only arms it, so the
        // PE always gets a one-cycle clear before the first window. From CAPT it arrives
        // already armed and FLUSH lasts a single cycle.
        FLUSH: begin
          cnt_q <= '0;
          if (pe_flush_q) begin
            pe_flush_q <= 1'b0;
            state_q    <= run_i ? MAC : IDLE;
          end else begin
            pe_flush_q <= 1'b1;
          end
        end
        IDLE: begin
          if (run_i) state_q <= MAC;
        end
        MAC: begin
          if (pix_valid_i) begin
            if (cnt_q == LAST) begin
              cnt_q   <= '0;
              state_q <= CAPT;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        CAPT: begin
          // Stalling here leaves pe_en low, so the PE keeps its sum until we can take it.
          if (res_load) begin
            res_data_q  <= capt_val;
            res_valid_q <= 1'b1;
            pe_flush_q  <= 1'b1;
            state_q     <= FLUSH;
          end
        end
        default: state_q <= FLUSH;
      endcase
    end
  end

  assign w_busy_o    = (state_q == MAC) || (state_q == CAPT);
  assign pix_ready_o = in_mac;
  assign pe_en_o     = in_mac && pix_valid_i;
  assign pe_flush_o  = pe_flush_q;
  assign pe_weight_o = kern_q[cnt_q];
  assign pe_pixel_o  = pix_data_i;
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;

endmodule

// File: tb/tb_pe_feeder_1st.sv
// Bench for pe_feeder_1st: behavioural PE, dot-product scoreboard, directed windows.
module tb_pe_feeder_1st;
  localparam int NW = 9;

  typedef logic [7:0] vec_t [NW];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        w_we = 1'b0;
  logic [3:0]  w_addr = '0;
  logic [7:0]  w_data = '0;
  logic        w_busy;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [7:0]  pix_data = '0;
  logic        pe_en, pe_flush;
  logic [7:0]  pe_weight, pe_pixel;
  logic [31:0] pe_result;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;

  int   checks = 0;
  int   errors = 0;
  vec_t kern_m;
  int   exp_q [$];
  int   acc = 0;
  int   hs_idx = 0;
  logic prev_v = 1'b0, prev_r = 1'b0;
  logic [31:0] prev_d = '0;

  always #5 clk = ~clk;

  pe_feeder_1st #(.K(3), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .run_i(run),
    .w_we_i(w_we), .w_addr_i(w_addr), .w_data_i(w_data), .w_busy_o(w_busy),
    .pix_valid_i(pix_valid), .pix_ready_o(pix_ready), .pix_data_i(pix_data),
    .pe_en_o(pe_en), .pe_flush_o(pe_flush), .pe_weight_o(pe_weight), .pe_pixel_o(pe_pixel),
    .pe_result_i(pe_result), .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_data_o(res_data)
  );

  // PE model: flush wins, else accumulate signed product; not reset on purpose.
  always @(posedge clk) begin
    if (pe_flush)   acc <= 0;
    else if (pe_en) acc <= acc + int'($signed(pe_weight)) * int'($signed(pe_pixel));
  end
  assign pe_result = 32'(acc);

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0b want=%0b", nm, act, exp);
    end
  endtask

  function automatic int dot(input vec_t k, input vec_t p);
    int s = 0;
    for (int i = 0; i < NW; i++) s += int'($signed(k[i])) * int'($signed(p[i]));
    return s;
  endfunction

  function automatic int post(input int v);
`ifdef PE_FEEDER_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  // Compare process: PE drive rules, output hold rule and in-order results.
  always @(negedge clk) begin
    if (!rst_n) begin
      hs_idx = 0;
      prev_v = 1'b0;
      prev_r = 1'b0;
    end else begin
      if (pe_flush) chk1("pe_en_with_flush", pe_en, 1'b0);
      chk1("pe_en_is_handshake", pe_en, pix_valid && pix_ready);
      if (pe_en) begin
        chk32("pe_weight", {24'b0, pe_weight}, {24'b0, kern_m[hs_idx]});
        chk32("pe_pixel", {24'b0, pe_pixel}, {24'b0, pix_data});
        hs_idx = (hs_idx == NW - 1) ? 0 : hs_idx + 1;
      end
      if (prev_v && !prev_r) begin
        chk1("res_valid_hold", res_valid, 1'b1);
        chk32("res_data_hold", res_data, prev_d);
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL res_unexpected got=%0h want=none", res_data);
        end else begin
          chk32("res_data", res_data, 32'(exp_q.pop_front()));
        end
      end
      prev_v = res_valid;
      prev_r = res_ready;
      prev_d = res_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_w(input logic [3:0] a, input logic [7:0] d);
    w_we = 1'b1; w_addr = a; w_data = d;
    tick();
    w_we = 1'b0;
  endtask

  task automatic load_kernel(input vec_t k);
    for (int i = 0; i < NW; i++) begin
      write_w(4'(i), k[i]);
      kern_m[i] = k[i];
    end
  endtask

  task automatic send_pixel(input logic [7:0] p, input int gap);
    logic hs;
    int   n;
    for (int g = 0; g < gap; g++) begin
      pix_valid = 1'b0;
      tick();
    end
    pix_valid = 1'b1;
    pix_data  = p;
    hs = 1'b0;
    n  = 0;
    while (!hs && n < 200) begin
      @(negedge clk);
      hs = pix_ready;
      tick();
      n++;
    end
    if (!hs) begin
      checks++;
      errors++;
      $display("FAIL pixel_timeout got=no_ready want=ready");
    end
    pix_valid = 1'b0;
  endtask

  task automatic send_window(input vec_t p, input int gap);
    for (int i = 0; i < NW; i++) send_pixel(p[i], gap);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || w_busy || res_valid) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got=%0d_pending want=0", exp_q.size());
    end
    repeat (3) tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk1({tag, "_pe_en"}, pe_en, 1'b0);
    chk1({tag, "_pe_flush"}, pe_flush, 1'b0);
    chk1({tag, "_pix_ready"}, pix_ready, 1'b0);
    chk1({tag, "_res_valid"}, res_valid, 1'b0);
    chk32({tag, "_res_data"}, res_data, 32'd0);
    chk1({tag, "_w_busy"}, w_busy, 1'b0);
    chk32({tag, "_pe_weight"}, {24'b0, pe_weight}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t ones, seq, neg1, p127, ka, pa, pb, k19, rev;
    int   t2exp;
    for (int i = 0; i < NW; i++) begin
      ones[i] = 8'd1;
      seq[i]  = 8'(i + 1);
      neg1[i] = 8'hFF;
      p127[i] = 8'd127;
      ka[i]   = (i % 2 == 1) ? 8'(-(i + 1)) : 8'(i + 1);
      pa[i]   = 8'(10 * (i + 1));
      pb[i]   = 8'(i - 5);
      k19[i]  = 8'(i + 1);
      rev[i]  = 8'(9 - i);
      kern_m[i] = 8'd0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) tick();

    // Model pins
    chk32("model_ones_seq", 32'(dot(ones, seq)), 32'd45);
    chk32("model_neg1_127", 32'(dot(neg1, p127)), 32'hFFFFFB89);

    // Test 1: all-ones kernel, pixels 1..9, latency and one-cycle valid.
    // Writes to addresses 9 and 15 are out of range and must not disturb the kernel.
    load_kernel(ones);
    write_w(4'd9, 8'd77);
    write_w(4'd15, 8'd88);
    exp_q.push_back(45);
    res_ready = 1'b1;
    run = 1'b1;
    send_window(seq, 0);
    run = 1'b0;
    @(negedge clk);
    chk1("t1_valid_t+1", res_valid, 1'b0);
    tick();
    @(negedge clk);
    chk1("t1_valid_t+2", res_valid, 1'b1);
    chk32("t1_data", res_data, 32'd45);
    chk1("t1_flush_t+2", pe_flush, 1'b1);
    tick();
    @(negedge clk);
    chk1("t1_valid_t+3", res_valid, 1'b0);
    chk1("t1_flush_t+3", pe_flush, 1'b0);
    drain();

    // Test 3: pix_valid gaps between every pixel
    exp_q.push_back(45);
    run = 1'b1;
    send_window(seq, 1);
    run = 1'b0;
    drain();

    // Test 2: kernel of -1 against pixels of 127
`ifdef PE_FEEDER_RELU_EN
    t2exp = 0;
`else
    t2exp = -1143;
`endif
    load_kernel(neg1);
    exp_q.push_back(t2exp);
    run = 1'b1;
    send_window(p127, 0);
    run = 1'b0;
    drain();

    // Test 4: two windows under backpressure; second stalls in CAPT without flushing
    load_kernel(ka);
    res_ready = 1'b0;
    exp_q.push_back(post(dot(ka, pa)));
    exp_q.push_back(post(dot(ka, pb)));
    run = 1'b1;
    send_window(pa, 0);
    send_window(pb, 0);
    run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk1("t4_stall_no_flush", pe_flush, 1'b0);
      chk1("t4_stall_busy", w_busy, 1'b1);
      chk1("t4_stall_valid", res_valid, 1'b1);
      tick();
    end
    res_ready = 1'b1;
    drain();

    // Test 5: kernel write during MAC is dropped for this and the next window
    load_kernel(k19);
    exp_q.push_back(post(dot(k19, seq)));
    exp_q.push_back(post(dot(k19, rev)));
    run = 1'b1;
    send_pixel(seq[0], 0);
    send_pixel(seq[1], 0);
    w_we = 1'b1; w_addr = 4'd0; w_data = 8'd5;
    @(negedge clk);
    chk1("t5_busy", w_busy, 1'b1);
    tick();
    w_we = 1'b0;
    for (int i = 2; i < NW; i++) send_pixel(seq[i], 0);
    send_window(rev, 0);
    run = 1'b0;
    drain();

    // Test 6: reset after four pixels, then a clean full window
    run = 1'b1;
    for (int i = 0; i < 4; i++) send_pixel(seq[i], 0);
    rst_n = 1'b0;
    run = 1'b0;
    for (int i = 0; i < NW; i++) kern_m[i] = 8'd0;
    #1;
    chk_reset_outputs("t6_rst");
    chk32("t6_no_pending", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    load_kernel(k19);
    exp_q.push_back(post(dot(k19, seq)));
    run = 1'b1;
    send_window(seq, 0);
    run = 1'b0;
    drain();

    chk32("all_results_seen", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
